bnmult_sched: RTL and testbench

- Shares one 16x16 parallel multiplier lane array (256-bit lanes) and its BN-parameter ROM between NREQ requesters, for example several channel groups issuing BN-ADD results.
- Accepts one 1024-bit vector at a time from a round-robin winner.
- Splits the vector into 4 lane beats, drives the matching ROM address with each beat, and reassembles the 4 result beats.
- Returns the full 1024-bit result with the requester id.

---
 rtl/bnmult_pkg.sv | 14 +
 rtl/bnmult_sched_rr_arb.sv | 37 +++
 rtl/bnmult_sched.sv | 135 +++++++++++++
 tb/tb_bnmult_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnmult_pkg.sv
// Shared constants and state encoding for the BN multiplier scheduler.
package bnmult_pkg;
    localparam int LANE_W = 256;
    localparam int BEATS  = 4;
    localparam int SEL_W  = $clog2(BEATS);
    localparam int CNT_W  = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/bnmult_sched_rr_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);
    localparam logic [IDW:0] NREQ_C = (IDW+1)'(NREQ);

    logic [NREQ-1:0] rot;
    logic [IDW:0]    pick;
    logic            found;

    // Rotating the doubled vector puts the pointer's requester at bit 0.
    assign rot = NREQ'({req, req} >> ptr);

    always_comb begin
        grant = '0;
        id    = '0;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pick  = {1'b0, ptr} + (IDW+1)'(k);
                if (pick >= NREQ_C) begin
                    pick = pick - NREQ_C;
                end
                id    = pick[IDW-1:0];
                grant = NREQ'(1) << pick;
            end
        end
    end
endmodule

// File: rtl/bnmult_sched.sv
// Time-shares one 256-bit multiplier lane array and its parameter ROM between
// several requesters, streaming each 1024-bit vector as four lane beats.
module bnmult_sched
    import bnmult_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DATA_W  = 1024,
    parameter int PADDR_W = 6,
    parameter int IDW     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_v_i,
    input  logic [NREQ*DATA_W-1:0]  req_data_i,
    input  logic [NREQ*PADDR_W-1:0] req_base_i,
    output logic [NREQ-1:0]         req_rdy_o,
    output logic [LANE_W-1:0]       mult_a_o,
    output logic                    mult_v_o,
    output logic [PADDR_W-1:0]      par_addr_o,
    input  logic [LANE_W-1:0]       mult_res_i,
    input  logic                    mult_res_v_i,
    output logic [DATA_W-1:0]       resp_data_o,
    output logic                    resp_v_o,
    output logic [IDW-1:0]          resp_id_o,
    output logic                    busy_o
);
    localparam logic [IDW:0] NREQ_C = (IDW+1)'(NREQ);

    state_t                          state;
    logic [IDW-1:0]                  ptr;
    logic [IDW-1:0]                  owner;
    logic [CNT_W-1:0]                tx_cnt;
    logic [CNT_W-1:0]                rx_cnt;
    logic [PADDR_W-1:0]              base;
    logic [BEATS-1:0][LANE_W-1:0]    data_buf;
    logic [BEATS-1:0][LANE_W-1:0]    res_buf;

    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     gid;
    logic               accept;
    logic [DATA_W-1:0]  sel_data;
    logic [PADDR_W-1:0] sel_base;
    logic [IDW:0]       inc;
    logic [IDW-1:0]     ptr_next;
    logic               collect;

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req_v_i),
        .ptr   (ptr),
        .grant (grant),
        .id    (gid)
    );

    assign req_rdy_o = (state == IDLE) ? grant : '0;
    assign accept    = |(req_v_i & req_rdy_o);
    assign busy_o    = (state != IDLE);
    assign collect   = (state == ISSUE || state == DRAIN) && mult_res_v_i
                       && (rx_cnt < CNT_W'(BEATS));

    always_comb begin
        sel_data = '0;
        sel_base = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gid == IDW'(k)) begin
                sel_data = req_data_i[k*DATA_W +: DATA_W];
                sel_base = req_base_i[k*PADDR_W +: PADDR_W];
            end
        end
        inc      = {1'b0, owner} + 1'b1;
        ptr_next = (inc >= NREQ_C) ? '0 : inc[IDW-1:0];
    end

    // Result beats are captured in ISSUE as well so a 1-cycle array still works.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            tx_cnt      <= '0;
            rx_cnt      <= '0;
            base        <= '0;
            data_buf    <= '0;
            res_buf     <= '0;
            mult_a_o    <= '0;
            mult_v_o    <= 1'b0;
            par_addr_o  <= '0;
            resp_data_o <= '0;
            resp_v_o    <= 1'b0;
            resp_id_o   <= '0;
        end else begin
            mult_v_o <= 1'b0;
            resp_v_o <= 1'b0;
            if (collect) begin
                res_buf[rx_cnt[SEL_W-1:0]] <= mult_res_i;
                rx_cnt                     <= rx_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_buf <= sel_data;
                        base     <= sel_base;
                        owner    <= gid;
                        tx_cnt   <= '0;
                        rx_cnt   <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mult_a_o   <= data_buf[tx_cnt[SEL_W-1:0]];
                    par_addr_o <= base + PADDR_W'(tx_cnt);
                    mult_v_o   <= 1'b1;
                    tx_cnt     <= tx_cnt + 1'b1;
                    if (tx_cnt == CNT_W'(BEATS-1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rx_cnt == CNT_W'(BEATS)) begin
                        resp_data_o <= res_buf;
                        resp_id_o   <= owner;
                        resp_v_o    <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    ptr    <= ptr_next;
                    tx_cnt <= '0;
                    rx_cnt <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bnmult_sched.sv
// Scoreboard bench for bnmult_sched with a latency-configurable lane-array model.
module tb_bnmult_sched;
    import bnmult_pkg::*;

    localparam int NREQ    = 2;
    localparam int DATA_W  = 1024;
    localparam int PADDR_W = 6;
    localparam int IDW     = 2;

    typedef struct {
        logic [IDW-1:0]    id;
        logic [DATA_W-1:0] data;
        int                lat;
    } resp_t;

    typedef struct {
        logic [PADDR_W-1:0] addr;
        logic [LANE_W-1:0]  lane;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_v_i;
    logic [NREQ*DATA_W-1:0]  req_data_i;
    logic [NREQ*PADDR_W-1:0] req_base_i;
    logic [NREQ-1:0]         req_rdy_o;
    logic [LANE_W-1:0]       mult_a_o;
    logic                    mult_v_o;
    logic [PADDR_W-1:0]      par_addr_o;
    logic [LANE_W-1:0]       mult_res_i;
    logic                    mult_res_v_i;
    logic [DATA_W-1:0]       resp_data_o;
    logic                    resp_v_o;
    logic [IDW-1:0]          resp_id_o;
    logic                    busy_o;

    resp_t             resp_q[$];
    beat_t             beat_q[$];
    int                errors = 0;
    int                checks = 0;
    int                cyc = 0;
    int                last_acc = 0;
    int                lat = 3;
    logic              inj_v;
    logic [LANE_W-1:0] inj_d;
    logic [NREQ-1:0]   hs;
    logic              pipe_v [0:3];
    logic [LANE_W-1:0] pipe_d [0:3];
    logic              mv;
    logic [LANE_W-1:0] md;

    bnmult_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .PADDR_W(PADDR_W), .IDW(IDW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_v_i      (req_v_i),
        .req_data_i   (req_data_i),
        .req_base_i   (req_base_i),
        .req_rdy_o    (req_rdy_o),
        .mult_a_o     (mult_a_o),
        .mult_v_o     (mult_v_o),
        .par_addr_o   (par_addr_o),
        .mult_res_i   (mult_res_i),
        .mult_res_v_i (mult_res_v_i),
        .resp_data_o  (resp_data_o),
        .resp_v_o     (resp_v_o),
        .resp_id_o    (resp_id_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Array model: each result lane is its input lane plus one, delayed so that
    // the result is captured lat edges after the beat was issued.
    always @(posedge clk) begin
        pipe_v[0] <= mult_v_o;
        pipe_d[0] <= mult_a_o + 1'b1;
        for (int i = 1; i < 4; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    always_comb begin
        mv = 1'b0;
        md = '0;
        case (lat)
            1:       begin mv = mult_v_o;  md = mult_a_o + 1'b1; end
            2:       begin mv = pipe_v[0]; md = pipe_d[0]; end
            3:       begin mv = pipe_v[1]; md = pipe_d[1]; end
            default: begin mv = pipe_v[2]; md = pipe_d[2]; end
        endcase
        mult_res_v_i = mv | inj_v;
        mult_res_i   = inj_v ? inj_d : md;
    end

    function automatic logic [DATA_W-1:0] mk(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] c, input logic [3:0] d);
        return {{64{d}}, {64{c}}, {64{b}}, {64{a}}};
    endfunction

    task automatic check_val(input string name, input logic [LANE_W-1:0] act,
                             input logic [LANE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int k = BEATS - 1; k >= 0; k--) begin
            if (act[k*LANE_W +: LANE_W] !== exp[k*LANE_W +: LANE_W]) bad = k;
        end
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s lane %0d: got %0h expected %0h", name, bad,
                     act[bad*LANE_W +: LANE_W], exp[bad*LANE_W +: LANE_W]);
        end
    endtask

    task automatic checkOutput();
        beat_t b;
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if ((req_v_i & req_rdy_o) != '0) last_acc = cyc + 1;
            if (req_v_i != '0) check_val("rdy_onehot", LANE_W'($onehot0(req_rdy_o)), 1);
            if (busy_o) check_val("rdy_low_busy", LANE_W'(req_rdy_o), 0);
            if (mult_v_o) begin
                if (beat_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_beat: got mult_v_o=1 expected none");
                end else begin
                    b = beat_q.pop_front();
                    check_val("par_addr", LANE_W'(par_addr_o), LANE_W'(b.addr));
                    check_val("mult_a", mult_a_o, b.lane);
                end
            end
            if (resp_v_o) begin
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_resp: got resp_v_o=1 expected none");
                end else begin
                    r = resp_q.pop_front();
                    check_val("resp_id", LANE_W'(resp_id_o), LANE_W'(r.id));
                    check_val("resp_latency", LANE_W'(cyc - last_acc), LANE_W'(r.lat));
                    check_data("resp_data", resp_data_o, r.data);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        hs = req_v_i & req_rdy_o;
        @(posedge clk);
        #1;
        req_v_i = req_v_i & ~hs;
    endtask

    task automatic wait_accept(input int r);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!hs[r] && n < 40);
        checks++;
        if (!hs[r]) begin
            errors++;
            $display("[TB] FAIL accept_timeout req%0d: got no accept expected accept", r);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy_o && n < 60);
        checks++;
        if (busy_o) begin
            errors++;
            $display("[TB] FAIL idle_timeout: got busy_o=1 expected 0");
        end
    endtask

    // Queue the expected beats and response for a transaction in service order.
    task automatic applyStimulus(input int r, input logic [DATA_W-1:0] d,
                                 input logic [PADDR_W-1:0] b, input int l);
        beat_t bt;
        resp_t rs;
        for (int k = 0; k < BEATS; k++) begin
            bt.addr = b + PADDR_W'(k);
            bt.lane = d[k*LANE_W +: LANE_W];
            beat_q.push_back(bt);
            rs.data[k*LANE_W +: LANE_W] = d[k*LANE_W +: LANE_W] + 1'b1;
        end
        rs.id  = IDW'(r);
        rs.lat = 5 + l;
        resp_q.push_back(rs);
    endtask

    task automatic drive(input int r, input logic [DATA_W-1:0] d, input logic [PADDR_W-1:0] b);
        req_data_i[r*DATA_W +: DATA_W]   = d;
        req_base_i[r*PADDR_W +: PADDR_W] = b;
        req_v_i[r]                       = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        req_v_i    = '0;
        req_data_i = '0;
        req_base_i = '0;
        inj_v      = 1'b0;
        inj_d      = '0;
        hs         = '0;
        fork
            checkOutput();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", LANE_W'(busy_o), 0);
        check_val("rst_mult_v", LANE_W'(mult_v_o), 0);
        check_val("rst_par_addr", LANE_W'(par_addr_o), 0);
        check_val("rst_resp_v", LANE_W'(resp_v_o), 0);
        check_val("rst_rdy", LANE_W'(req_rdy_o), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single request, latency 3, base 10.
        lat = 3;
        applyStimulus(0, mk(4'h0, 4'h1, 4'h2, 4'h3), 6'd10, 3);
        drive(0, mk(4'h0, 4'h1, 4'h2, 4'h3), 6'd10);
        wait_accept(0);
        wait_idle();

        // Address wrap at base 62 with a 1-cycle array.
        lat = 1;
        applyStimulus(1, mk(4'h4, 4'h5, 4'h6, 4'h7), 6'd62, 1);
        drive(1, mk(4'h4, 4'h5, 4'h6, 4'h7), 6'd62);
        wait_accept(1);
        wait_idle();

        // Spurious results while idle, then a 5th beat after all four arrived.
        lat   = 3;
        inj_d = {64{4'h9}};
        inj_v = 1'b1;
        repeat (3) step();
        inj_v = 1'b0;
        step();
        applyStimulus(1, mk(4'h8, 4'h9, 4'ha, 4'hb), 6'd20, 3);
        drive(1, mk(4'h8, 4'h9, 4'ha, 4'hb), 6'd20);
        wait_accept(1);
        repeat (7) step();
        inj_d = {64{4'he}};
        inj_v = 1'b1;
        step();
        step();
        inj_v = 1'b0;
        wait_idle();
        applyStimulus(0, mk(4'hc, 4'hd, 4'he, 4'hf), 6'd30, 3);
        drive(0, mk(4'hc, 4'hd, 4'he, 4'hf), 6'd30);
        wait_accept(0);
        wait_idle();

        // Asynchronous reset while draining; the transaction must vanish.
        applyStimulus(1, mk(4'h1, 4'h3, 4'h5, 4'h7), 6'd40, 3);
        drive(1, mk(4'h1, 4'h3, 4'h5, 4'h7), 6'd40);
        wait_accept(1);
        repeat (4) step();
        #1;
        rst = 1'b1;
        #1;
        check_val("arst_busy", LANE_W'(busy_o), 0);
        check_val("arst_mult_v", LANE_W'(mult_v_o), 0);
        check_val("arst_par_addr", LANE_W'(par_addr_o), 0);
        check_val("arst_mult_a", mult_a_o, 0);
        check_val("arst_resp_data", LANE_W'(|resp_data_o), 0);
        beat_q.delete();
        resp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Both requesters held valid: strict alternation starting at 0.
        applyStimulus(0, mk(4'h2, 4'h4, 4'h6, 4'h8), 6'd50, 3);
        applyStimulus(1, mk(4'h3, 4'h5, 4'h7, 4'h9), 6'd51, 3);
        applyStimulus(0, mk(4'ha, 4'hb, 4'hc, 4'hd), 6'd52, 3);
        applyStimulus(1, mk(4'he, 4'hd, 4'hc, 4'hb), 6'd53, 3);
        drive(0, mk(4'h2, 4'h4, 4'h6, 4'h8), 6'd50);
        drive(1, mk(4'h3, 4'h5, 4'h7, 4'h9), 6'd51);
        wait_accept(0);
        drive(0, mk(4'ha, 4'hb, 4'hc, 4'hd), 6'd52);
        wait_accept(1);
        drive(1, mk(4'he, 4'hd, 4'hc, 4'hb), 6'd53);
        wait_accept(0);
        wait_accept(1);
        wait_idle();
        repeat (3) step();

        check_val("beats_left", LANE_W'(beat_q.size()), 0);
        check_val("resps_left", LANE_W'(resp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
